reaction_delay: RTL and testbench
=================================

# reaction_delay

Stimulus generator that sits directly upstream of the reaction-time counter in the reaction timer. After the player presses the trigger, it waits a pseudo-random number of milliseconds, then lights the stimulus LED. It also asserts `start_count`, which the counter samples on its `tick_ms` edge and uses to clear and start counting. With the false-start feature compiled in, a `stop` press during the wait is flagged and no stimulus is issued.

## Interface
- `MIN_DELAY_MS`, 1000: fixed part of the wait, in ms.
- `RAND_BITS`, 12: width of the random part of the wait (0 to 2^RAND_BITS-1 ms).
- `DELAY_BITS`, 14: width of the wait counter. Constraint: MIN_DELAY_MS + 2^RAND_BITS - 1 < 2^DELAY_BITS.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- `clk`  in  1  system clock; every register is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tick_ms`  in  1  one-`clk`-wide enable pulse, once per millisecond.
- `trigger`  in  1  start button; synchronised, level, active-high.
- `stop`  in  1  response button; synchronised, level, active-high. The same signal is also wired to the counter.
- `led`  out  1  stimulus LED.
- `start_count`  out  1  start request to the counter.
- `false_start`  out  1  sticky false-start indication.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Reset values: all outputs 0, state IDLE, LFSR = LFSR_SEED, wait counter 0, trigger history 0.
- LFSR:
  - 16-bit Galois LFSR, tap mask 16'hB400.
  - Advances on every `clk` cycle, in every state.
- Trigger edge: `trigger`=1 while the registered previous `trigger`=0. Edges are acted on only in IDLE and FALSE.
- Wait load: on an accepted trigger edge, wait counter = MIN_DELAY_MS + lfsr[RAND_BITS-1:0]. Zero-extend to DELAY_BITS.
- States:
  - IDLE: all outputs 0. Trigger edge → load counter, go to WAIT.
  - WAIT: `busy`=1.
    - On `tick_ms`, decrement the counter.
    - On `tick_ms` with counter==1 → go to GO. The wait is therefore exactly N ticks after load.
    - With `REACTION_FALSE_START_EN`: `stop`=1 → go to FALSE. If `stop` and the final tick arrive in the same cycle, `stop` wins.
  - GO: `led`=1, `busy`=1.
    - `start_count` rises on entry. It stays high through the first `tick_ms` pulse seen in GO and clears on the following `clk` edge.
    - `stop`=1 → go to IDLE. If `stop` arrives while `start_count` is still high, `start_count` still completes its tick window and the state returns to IDLE afterwards.
  - FALSE: `false_start`=1, `busy`=1, `led`=0. Trigger edge → clear `false_start`, load counter, go to WAIT.
- `reset` asserted in any state forces all reset values immediately.

## Timing
- Outputs are registered; each output changes on the `clk` edge that enters or leaves its state.
- Trigger edge → WAIT: 1 cycle.
- Wait length: MIN_DELAY_MS + R ms, where R is the sampled LFSR field. It is measured in `tick_ms` pulses, so the first partial ms counts as a full tick.
- `start_count` is stable for at least one full `tick_ms` period. It is high at the `tick_ms` edge the counter samples.
- `stop` → leave GO or enter FALSE: 1 cycle.

## Configuration
- Macro: `REACTION_FALSE_START_EN`.
- Defined:
  - `stop` during WAIT enters FALSE and sets `false_start`.
  - FALSE is the only exit from a false start, via a new trigger edge.
- Undefined:
  - `stop` is ignored in WAIT.
  - FALSE is unreachable and removed.
  - `false_start` is tied to 0.

## Structure
- Shared package `reaction_pkg`:
  - State encoding: S_IDLE, S_WAIT, S_GO, S_FALSE.
  - LFSR tap constant 16'hB400.
  - Default MIN_DELAY_MS.
- One sub-module: `lfsr16` (free-running Galois LFSR with seed parameter, `clk`/`reset`, 16-bit output).
- FSM, edge detect and wait counter stay in `reaction_delay`.

## Test plan
- Reset release: all outputs 0. After 3 clk cycles the LFSR has taken its 3rd successor of 16'hACE1, checked against a reference model.
- MIN_DELAY_MS=5, RAND_BITS=2, trigger edge with lfsr[1:0]=2: `led` rises after exactly 7 `tick_ms` pulses. `start_count` is high across the 8th pulse and low one cycle later.
- `stop` in GO: `led` falls 1 cycle later; state IDLE, `busy`=0. A trigger held high since the start does not retrigger.
- With the macro defined: `stop` after 3 of 7 ticks → `false_start`=1, `led` never rises. A new trigger edge clears `false_start` and restarts WAIT.
- Without the macro: same stimulus → `stop` ignored; `led` rises after 7 ticks.
- `reset` pulsed mid-WAIT and mid-GO: outputs go to 0 asynchronously before the next clk edge. No `start_count` follows.

Source files
------------

// File: rtl/reaction_pkg.sv
// reaction_pkg: shared types and constants for the reaction-timer stimulus path.
// State encoding, LFSR tap mask, default fixed wait and the LFSR step helper.
package reaction_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_GO    = 2'd2,
    S_FALSE = 2'd3
  } state_t;

  // Galois feedback mask applied when the bit shifted out is 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Default fixed part of the random wait, in milliseconds
  localparam int DEFAULT_MIN_DELAY_MS = 1000;

  // One right-shift step of the 16-bit Galois LFSR
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] shifted;
    shifted = {1'b0, v[15:1]};
    if (v[0]) begin
      lfsr_next = shifted ^ LFSR_TAPS;
    end else begin
      lfsr_next = shifted;
    end
  endfunction

endpackage

// File: rtl/reaction_delay_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR used as the random source for the
// stimulus wait. Steps on every clock regardless of what the FSM is doing.
module lfsr16
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;

  // Advance the LFSR every cycle; a zero seed would lock it up, so SEED must be nonzero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/reaction_delay.sv
// reaction_delay: waits MIN_DELAY_MS plus a pseudo-random number of tick_ms
// pulses after a trigger press, then lights the LED and raises start_count
// until the counter has seen one tick.
// Optional false-start detection is compiled in with REACTION_FALSE_START_EN.
module reaction_delay
  import reaction_pkg::*;
#(
  parameter int          MIN_DELAY_MS = DEFAULT_MIN_DELAY_MS,
  parameter int          RAND_BITS    = 12,
  parameter int          DELAY_BITS   = 14,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_ms,
  input  logic trigger,
  input  logic stop,
  output logic led,
  output logic start_count,
  output logic false_start,
  output logic busy
);

  localparam logic [DELAY_BITS-1:0] CNT_ONE = DELAY_BITS'(1);
  localparam logic [DELAY_BITS-1:0] CNT_MIN = DELAY_BITS'(MIN_DELAY_MS);

  logic [15:0]           w_lfsr;
  logic [DELAY_BITS-1:0] w_load;
  logic                  w_trig_edge;
  logic                  w_unused;

  state_t                r_state;
  logic [DELAY_BITS-1:0] r_cnt;
  logic                  r_trig_prev;
  logic                  r_led;
  logic                  r_start;
  logic                  r_busy;
  logic                  r_stop_pend;
`ifdef REACTION_FALSE_START_EN
  logic                  r_false;
`endif

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .o_lfsr (w_lfsr)
  );

  // Only the low RAND_BITS of the LFSR feed the wait; the rest just keep the sequence long
  assign w_unused    = ^w_lfsr;
  assign w_load      = CNT_MIN + DELAY_BITS'(w_lfsr[RAND_BITS-1:0]);
  assign w_trig_edge = trigger & ~r_trig_prev;

  // Stimulus FSM with edge history, wait counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_trig_prev <= 1'b0;
      r_led       <= 1'b0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_stop_pend <= 1'b0;
`ifdef REACTION_FALSE_START_EN
      r_false     <= 1'b0;
`endif
    end else begin
      r_trig_prev <= trigger;
      case (r_state)
        S_IDLE: begin
          r_led       <= 1'b0;
          r_start     <= 1'b0;
          r_stop_pend <= 1'b0;
          if (w_trig_edge) begin
            r_cnt   <= w_load;
            r_state <= S_WAIT;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end

        S_WAIT: begin
`ifdef REACTION_FALSE_START_EN
          // A press during the wait beats a coincident final tick
          if (stop) begin
            r_state <= S_FALSE;
            r_false <= 1'b1;
          end else
`endif
          if (tick_ms) begin
            // The N-th tick after loading N ends the wait; a zero load acts as one tick
            if (r_cnt <= CNT_ONE) begin
              r_state     <= S_GO;
              r_led       <= 1'b1;
              r_start     <= 1'b1;
              r_stop_pend <= 1'b0;
            end
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        S_GO: begin
          if (r_start) begin
            // start_count must be seen by the counter on one tick before any stop takes effect
            if (tick_ms) begin
              r_start <= 1'b0;
              if (stop || r_stop_pend) begin
                r_state     <= S_IDLE;
                r_led       <= 1'b0;
                r_busy      <= 1'b0;
                r_stop_pend <= 1'b0;
              end
            end else if (stop) begin
              r_stop_pend <= 1'b1;
            end
          end else if (stop) begin
            r_state     <= S_IDLE;
            r_led       <= 1'b0;
            r_busy      <= 1'b0;
            r_stop_pend <= 1'b0;
          end
        end

`ifdef REACTION_FALSE_START_EN
        S_FALSE: begin
          r_led <= 1'b0;
          if (w_trig_edge) begin
            r_false <= 1'b0;
            r_cnt   <= w_load;
            r_state <= S_WAIT;
          end
        end
`endif

        default: begin
          r_state     <= S_IDLE;
          r_led       <= 1'b0;
          r_start     <= 1'b0;
          r_busy      <= 1'b0;
          r_stop_pend <= 1'b0;
        end
      endcase
    end
  end

  assign led         = r_led;
  assign start_count = r_start;
  assign busy        = r_busy;
`ifdef REACTION_FALSE_START_EN
  assign false_start = r_false;
`else
  assign false_start = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_delay.sv
// tb_reaction_delay: randomized self-checking bench for reaction_delay.
// Expected wait lengths come from a bench-side LFSR model and tick counting.
module tb_reaction_delay;

  localparam int          MIN_MS = 5;
  localparam int          RB     = 2;
  localparam int          DB     = 4;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic tick_ms = 1'b0;
  logic trigger = 1'b0;
  logic stop    = 1'b0;
  logic led, start_count, false_start, busy;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc;
  int          tick_edges = 0;
  logic [15:0] m_lfsr;

  reaction_delay #(
    .MIN_DELAY_MS (MIN_MS),
    .RAND_BITS    (RB),
    .DELAY_BITS   (DB),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_ms     (tick_ms),
    .trigger     (trigger),
    .stop        (stop),
    .led         (led),
    .start_count (start_count),
    .false_start (false_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] v;
    v = SEED;
    for (int k = 0; k < n; k++) v = lfsr_step(v);
    return v;
  endfunction

  // reference LFSR value and cycle count since the last reset release
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc    <= 0;
      m_lfsr <= SEED;
    end else begin
      cyc    <= cyc + 1;
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  // count tick pulses as the DUT samples them
  always @(posedge clk) begin
    if (tick_ms) tick_edges <= tick_edges + 1;
  end

  // one-cycle tick pulses with random spacing
  initial begin
    forever begin
      repeat ($urandom_range(5, 2)) @(posedge clk);
      #1 tick_ms = 1'b1;
      @(posedge clk);
      #1 tick_ms = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Press trigger; returns expected wait length and tick base after the load edge
  task automatic start_trial(input int want_r, output int n, output int base);
    if (want_r >= 0) begin
      for (int i = 0; i < 64 && (int'(m_lfsr[RB-1:0]) != want_r); i++) step();
    end
    check_eq("lfsr_track", dut.u_lfsr.o_lfsr, m_lfsr);
    n = MIN_MS + int'(m_lfsr[RB-1:0]);
    trigger = 1'b1;
    step();
    check_eq("wait_busy", busy, 1'b1);
    check_eq("wait_led", led, 1'b0);
    base = tick_edges;
  endtask

  task automatic wait_led(input int base, input int n);
    bit rose;
    rose = 1'b0;
    for (int i = 0; i < 400 && !rose; i++) begin
      step();
      if (led) rose = 1'b1;
    end
    check_eq("led_rose", rose, 1'b1);
    if (rose) begin
      check_eq("led_rise_ticks", tick_edges - base, n);
      check_eq("sc_on_entry", start_count, 1'b1);
      check_eq("go_busy", busy, 1'b1);
    end
  endtask

  // start_count holds until the first tick in GO, then clears; then stop ends GO
  task automatic finish_go();
    int  base;
    bit  ok, done;
    base = tick_edges;
    ok   = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      if (tick_edges != base) begin
        done = 1'b1;
        check_eq("sc_clear", start_count, 1'b0);
        check_eq("led_hold", led, 1'b1);
      end else if (!start_count) begin
        ok = 1'b0;
      end
    end
    check_eq("sc_tick_seen", done, 1'b1);
    check_eq("sc_held", ok, 1'b1);
    repeat ($urandom_range(3, 0)) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("stop_led", led, 1'b0);
    check_eq("stop_busy", busy, 1'b0);
    ok = 1'b1;
    repeat (20) begin
      step();
      if (busy || led || start_count) ok = 1'b0;
    end
    check_eq("no_retrigger", ok, 1'b1);
    trigger = 1'b0;
    step();
  endtask

  task automatic reset_pulse();
    bit ok;
    #2 reset = 1'b1;
    trigger = 1'b0;
    #2;
    check_eq("rst_led", led, 1'b0);
    check_eq("rst_sc", start_count, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_false", false_start, 1'b0);
    #3 reset = 1'b0;
    ok = 1'b1;
    repeat (60) begin
      step();
      if (busy || led || start_count || false_start) ok = 1'b0;
    end
    check_eq("rst_quiet", ok, 1'b1);
  endtask

  task automatic run_trial(input int mode, input int want_r);
    int n, base, b2;
    bit ok, done;
    start_trial(want_r, n, base);
    case (mode)
      0: begin
        wait_led(base, n);
        finish_go();
      end
      1: begin
        wait_led(base, n);
        b2   = tick_edges;
        stop = 1'b1;
        step();
        stop = 1'b0;
        ok   = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
          if (tick_edges != b2) begin
            done = 1'b1;
            check_eq("pend_sc", start_count, 1'b0);
            check_eq("pend_led", led, 1'b0);
            check_eq("pend_busy", busy, 1'b0);
          end else begin
            if (!(led && start_count && busy)) ok = 1'b0;
            step();
          end
        end
        check_eq("pend_done", done, 1'b1);
        check_eq("pend_hold", ok, 1'b1);
        trigger = 1'b0;
        step();
      end
      2: begin
        for (int i = 0; i < 400 && (tick_edges - base) < 3; i++) step();
        check_eq("fs_ticks", tick_edges - base, 3);
        stop = 1'b1;
        step();
        stop = 1'b0;
`ifdef REACTION_FALSE_START_EN
        check_eq("fs_set", false_start, 1'b1);
        check_eq("fs_busy", busy, 1'b1);
        ok = 1'b1;
        repeat (80) begin
          step();
          if (!false_start || !busy || led || start_count) ok = 1'b0;
        end
        check_eq("fs_sticky", ok, 1'b1);
        trigger = 1'b0;
        step();
        step();
        n = MIN_MS + int'(m_lfsr[RB-1:0]);
        trigger = 1'b1;
        step();
        check_eq("fs_clear", false_start, 1'b0);
        check_eq("fs_rewait", busy, 1'b1);
        base = tick_edges;
        wait_led(base, n);
        finish_go();
`else
        check_eq("fs_off", false_start, 1'b0);
        wait_led(base, n);
        finish_go();
`endif
      end
      3: begin
        repeat (2) step();
        reset_pulse();
      end
      default: begin
        wait_led(base, n);
        reset_pulse();
      end
    endcase
  endtask

  initial begin
    #12;
    check_eq("reset_led", led, 1'b0);
    check_eq("reset_sc", start_count, 1'b0);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_false", false_start, 1'b0);
    #1 reset = 1'b0;
    repeat (3) step();
    check_eq("lfsr_3rd", dut.u_lfsr.o_lfsr, lfsr_after(3));
    check_eq("idle_busy", busy, 1'b0);

    run_trial(0, 2);
    run_trial(2, 2);
    run_trial(1, -1);
    run_trial(3, -1);
    run_trial(4, -1);
    for (int t = 0; t < 20; t++) begin
      run_trial(int'($urandom_range(4, 0)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
